// File: rtl/mult_fu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_fu
//  Purpose  : Pipelined integer multiply functional unit (MUL, MULH, MULHSU,
//             MULHU). Results are tagged with a PRF/ROB index and are handed
//             toward the CDB through a valid/ready handshake. Bubbles collapse
//             under output backpressure, and a squash flushes every in-flight op.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   1        system clock, rising edge
//    reset          in   1        asynchronous, active-high reset
//    squash         in   1        mispredict flush, kills all in-flight ops
//    in_valid       in   1        issue request from the reservation station
//    in_ready       out  1        unit can accept an op this cycle
//    in_func        in   2        0=MUL 1=MULH 2=MULHSU 3=MULHU
//    in_opa/in_opb  in   XLEN     operands
//    in_prf_entry   in   PRF_LEN  destination physical register
//    in_rob_entry   in   ROB_LEN  ROB index
//    mult_valid     out  1        result present
//    mult_ready     in   1        CDB accepts the result
//    mult_value     out  XLEN     result value
//    mult_prf_entry out  PRF_LEN  destination tag of the result
//    mult_rob_entry out  ROB_LEN  ROB index of the result
// ============================================================================
module mult_fu #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5,
    parameter int STAGES  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_func,
    input  logic [XLEN-1:0]    in_opa,
    input  logic [XLEN-1:0]    in_opb,
    input  logic [PRF_LEN-1:0] in_prf_entry,
    input  logic [ROB_LEN-1:0] in_rob_entry,
    output logic               mult_valid,
    input  logic               mult_ready,
    output logic [XLEN-1:0]    mult_value,
    output logic [PRF_LEN-1:0] mult_prf_entry,
    output logic [ROB_LEN-1:0] mult_rob_entry
);

    localparam int c_LAST = STAGES - 1;
    localparam int c_PW   = 2 * XLEN;     // full product width
    localparam int c_HALF = XLEN / 2;     // split point of operand B

    localparam logic [1:0] c_FUNC_MUL    = 2'd0;
    localparam logic [1:0] c_FUNC_MULHSU = 2'd2;
    localparam logic [1:0] c_FUNC_MULHU  = 2'd3;

    // ------------------------------------------------------------------------
    // Stage control
    // ------------------------------------------------------------------------
    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  valid_d;
    logic [STAGES-1:0]  w_adv;    // stage i hands its content forward
    logic [STAGES-1:0]  w_load;   // stage i takes content from behind
    logic               w_accept;

    logic [PRF_LEN-1:0] prf_q [STAGES];
    logic [ROB_LEN-1:0] rob_q [STAGES];

    // Advance ripples back from the output: a stage may move when the stage in
    // front of it is empty or is itself moving, so only stages behind a full,
    // stalled stage are held.
    always_comb begin : p_adv
        logic chain;
        w_adv         = '0;
        chain         = !valid_q[c_LAST] || mult_ready;
        w_adv[c_LAST] = chain;
        for (int i = STAGES - 2; i >= 0; i--) begin
            chain    = !valid_q[i+1] || chain;
            w_adv[i] = chain;
        end
    end

    assign w_load   = ~valid_q | w_adv;
    assign in_ready = w_load[0];
    assign w_accept = in_valid && in_ready && !squash;

    always_comb begin
        valid_d = valid_q;
        if (squash) begin
            valid_d = '0;
        end else begin
            if (w_load[0]) begin
                valid_d[0] = in_valid;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    valid_d[i] = valid_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prf_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (w_accept) begin
                prf_q[0] <= in_prf_entry;
                rob_q[0] <= in_rob_entry;
            end
            // Payload moves only with a real op so idle stages keep old data.
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i] && valid_q[i-1]) begin
                    prf_q[i] <= prf_q[i-1];
                    rob_q[i] <= rob_q[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Partial products
    //   Operands are extended (signed or unsigned per func) and the product is
    //   formed modulo 2^(2*XLEN). B is split into an unsigned low half and an
    //   extended high half: A*B = A*B_lo + (A*B_hi << HALF). The high partial
    //   product only needs 2*XLEN-HALF bits because of the shift.
    // ------------------------------------------------------------------------
    logic                   w_a_sx;
    logic                   w_b_sx;
    logic [c_PW-1:0]        w_a_full;
    logic [c_PW-c_HALF-1:0] w_a_hi;
    logic [c_PW-1:0]        w_b_lo;
    logic [c_PW-c_HALF-1:0] w_b_hi;
    logic [c_PW-1:0]        w_pp_lo;
    logic [c_PW-c_HALF-1:0] w_pp_hi;

    assign w_a_sx   = in_opa[XLEN-1] && (in_func != c_FUNC_MULHU);
    assign w_b_sx   = in_opb[XLEN-1] && (in_func != c_FUNC_MULHU)
                                     && (in_func != c_FUNC_MULHSU);
    assign w_a_full = {{XLEN{w_a_sx}}, in_opa};
    assign w_a_hi   = {{(XLEN-c_HALF){w_a_sx}}, in_opa};
    assign w_b_lo   = {{(c_PW-c_HALF){1'b0}}, in_opb[c_HALF-1:0]};
    assign w_b_hi   = {{XLEN{w_b_sx}}, in_opb[XLEN-1:c_HALF]};
    assign w_pp_lo  = w_a_full * w_b_lo;
    assign w_pp_hi  = w_a_hi * w_b_hi;

    function automatic logic [XLEN-1:0] pick_half(input logic [1:0]      func,
                                                  input logic [c_PW-1:0] prod);
        if (func == c_FUNC_MUL) begin
            return prod[XLEN-1:0];
        end
        return prod[c_PW-1:XLEN];
    endfunction

    generate
        if (STAGES == 1) begin : g_single
            // Whole multiply resolved into the only stage.
            logic [XLEN-1:0] res_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    res_q <= '0;
                end else if (w_accept) begin
                    res_q <= pick_half(in_func, w_pp_lo + {w_pp_hi, {c_HALF{1'b0}}});
                end
            end

            assign mult_value = res_q;
        end else begin : g_multi
            // S0 holds the two partial products, S1 sums and selects the
            // half, later stages only carry the finished result.
            logic [1:0]             func_q;
            logic [c_PW-1:0]        pp_lo_q;
            logic [c_PW-c_HALF-1:0] pp_hi_q;
            logic [XLEN-1:0]        res_q [1:c_LAST];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    func_q  <= '0;
                    pp_lo_q <= '0;
                    pp_hi_q <= '0;
                    for (int i = 1; i < STAGES; i++) begin
                        res_q[i] <= '0;
                    end
                end else begin
                    if (w_accept) begin
                        func_q  <= in_func;
                        pp_lo_q <= w_pp_lo;
                        pp_hi_q <= w_pp_hi;
                    end
                    if (w_load[1] && valid_q[0]) begin
                        res_q[1] <= pick_half(func_q, pp_lo_q + {pp_hi_q, {c_HALF{1'b0}}});
                    end
                    for (int i = 2; i < STAGES; i++) begin
                        if (w_load[i] && valid_q[i-1]) begin
                            res_q[i] <= res_q[i-1];
                        end
                    end
                end
            end

            assign mult_value = res_q[c_LAST];
        end
    endgenerate

    assign mult_valid     = valid_q[c_LAST];
    assign mult_prf_entry = prf_q[c_LAST];
    assign mult_rob_entry = rob_q[c_LAST];

endmodule
`default_nettype wire

// File: tb/tb_mult_fu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mult_fu
//  Purpose  : Self-checking bench for mult_fu (XLEN=32, STAGES=4). Expected
//             results are queued at issue and compared at each output
//             handshake; timing behaviours are checked inline by each test.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_fu;

    localparam int XLEN    = 32;
    localparam int PRF_LEN = 6;
    localparam int ROB_LEN = 5;
    localparam int STAGES  = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               squash;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_func;
    logic [XLEN-1:0]    in_opa;
    logic [XLEN-1:0]    in_opb;
    logic [PRF_LEN-1:0] in_prf_entry;
    logic [ROB_LEN-1:0] in_rob_entry;
    logic               mult_valid;
    logic               mult_ready;
    logic [XLEN-1:0]    mult_value;
    logic [PRF_LEN-1:0] mult_prf_entry;
    logic [ROB_LEN-1:0] mult_rob_entry;

    mult_fu #(
        .XLEN    (XLEN),
        .PRF_LEN (PRF_LEN),
        .ROB_LEN (ROB_LEN),
        .STAGES  (STAGES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_func        (in_func),
        .in_opa         (in_opa),
        .in_opb         (in_opb),
        .in_prf_entry   (in_prf_entry),
        .in_rob_entry   (in_rob_entry),
        .mult_valid     (mult_valid),
        .mult_ready     (mult_ready),
        .mult_value     (mult_value),
        .mult_prf_entry (mult_prf_entry),
        .mult_rob_entry (mult_rob_entry)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XLEN-1:0]    v;
        logic [PRF_LEN-1:0] p;
        logic [ROB_LEN-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   out_cyc[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: architectural definition of the four operations.
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (f == 2'd3) ? {32'b0, a} : {{32{a[31]}}, a};
        be = (f[1])      ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ae * be;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Scoreboard: every completed handshake must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && mult_valid && mult_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL result_unexpected: got value=%h prf=%0d rob=%0d, required no result",
                         mult_value, mult_prf_entry, mult_rob_entry);
            end else begin
                mon_e = sb.pop_front();
                if ({mult_value, mult_prf_entry, mult_rob_entry} !== mon_e)
                    $display("FAIL result: got value=%h prf=%0d rob=%0d, required value=%h prf=%0d rob=%0d",
                             mult_value, mult_prf_entry, mult_rob_entry, mon_e.v, mon_e.p, mon_e.r);
                else
                    n_pass++;
            end
            out_cyc.push_back(cyc);
        end
    end

    // Drives one op and waits (bounded) for it to be accepted; returns 1ns
    // after the accepting edge.
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] p, input logic [4:0] r, input logic [31:0] ev);
        int k;
        in_valid = 1'b1; in_func = f; in_opa = a; in_opb = b;
        in_prf_entry = p; in_rob_entry = r;
        k = 0;
        @(negedge clock);
        while (!in_ready && k < 60) begin
            k++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL issue_timeout: in_ready=%b, required 1 within 60 cycles", in_ready);
        end else begin
            sb.push_back({ev, p, r});
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || mult_valid) && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        n_checks++;
        if (sb.size() != 0 || mult_valid)
            $display("FAIL %s_drain: pending=%0d mult_valid=%b, required 0 and 0", name, sb.size(), mult_valid);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; squash = 1'b0; in_valid = 1'b0; in_func = '0;
        in_opa = '0; in_opb = '0; in_prf_entry = '0; in_rob_entry = '0;
        mult_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({mult_valid, mult_value, mult_prf_entry, mult_rob_entry} !== '0)
            $display("FAIL reset_outputs: got valid=%b value=%h prf=%0d rob=%0d, required all 0",
                     mult_valid, mult_value, mult_prf_entry, mult_rob_entry);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_latency();
        issue(2'd0, 32'd7, 32'd6, 6'd5, 5'd3, 32'd42);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if (mult_valid !== (k == 3))
                $display("FAIL latency_valid_cycle%0d: got %b, required %b", k, mult_valid, (k == 3));
            else n_pass++;
        end
        @(posedge clock); #1;
        wait_drain("latency");
    endtask

    task automatic test_back_to_back();
        out_cyc.delete();
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 5'd1, 32'h0000_0000);
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11, 5'd2, 32'hFFFF_FFFE);
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 5'd3, 32'hFFFF_FFFF);
        issue(2'd0, 32'h8000_0000, 32'h0000_0002, 6'd13, 5'd4, 32'h0000_0000);
        wait_drain("b2b");
        n_checks++;
        if (out_cyc.size() != 4 || out_cyc[3] - out_cyc[0] != 3)
            $display("FAIL b2b_consecutive: got %0d results over span %0d, required 4 over span 3",
                     out_cyc.size(), (out_cyc.size() == 4) ? out_cyc[3] - out_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        out_cyc.delete();
        mult_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'd1000 * i + 32'd3; b = 32'hFFFF_FFF0 + i;
            issue(2'(i), a, b, 6'(20 + i), 5'(8 + i), model(2'(i), a, b));
        end
        fork
            begin
                a = 32'h7FFF_FFFF; b = 32'h8000_0001;
                issue(2'd2, a, b, 6'd30, 5'd14, model(2'd2, a, b));
                issue(2'd1, b, a, 6'd31, 5'd15, model(2'd1, b, a));
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    n_checks++;
                    if (in_ready !== 1'b0 || mult_valid !== 1'b1 ||
                        {mult_value, mult_prf_entry, mult_rob_entry} !== sb[0])
                        $display("FAIL stall_hold%0d: got ready=%b valid=%b value=%h prf=%0d rob=%0d, required ready=0 valid=1 value=%h prf=%0d rob=%0d",
                                 k, in_ready, mult_valid, mult_value, mult_prf_entry, mult_rob_entry,
                                 sb[0].v, sb[0].p, sb[0].r);
                    else n_pass++;
                end
                @(posedge clock); #1;
                mult_ready = 1'b1;
            end
        join
        wait_drain("stall");
        n_checks++;
        if (out_cyc.size() != 6) $display("FAIL stall_count: got %0d results, required 6", out_cyc.size());
        else n_pass++;
    endtask

    task automatic test_bubble();
        out_cyc.delete();
        mult_ready = 1'b0;
        issue(2'd0, 32'd123, 32'd456, 6'd40, 5'd20, 32'd56088);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL bubble_gap%0d_ready: got %b, required 1", k, in_ready);
            else n_pass++;
            @(posedge clock); #1;
        end
        issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 6'd41, 5'd21, model(2'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || mult_valid !== 1'b1 || mult_value !== 32'd56088)
            $display("FAIL bubble_collapsed: got ready=%b valid=%b value=%h, required ready=1 valid=1 value=%h",
                     in_ready, mult_valid, mult_value, 32'd56088);
        else n_pass++;
        @(posedge clock); #1;
        mult_ready = 1'b1;
        wait_drain("bubble");
        n_checks++;
        if (out_cyc.size() != 2 || out_cyc[1] - out_cyc[0] != 1)
            $display("FAIL bubble_consecutive: got %0d results span %0d, required 2 span 1",
                     out_cyc.size(), (out_cyc.size() == 2) ? out_cyc[1] - out_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_squash();
        logic seen;
        mult_ready = 1'b0;
        issue(2'd0, 32'd3, 32'd5, 6'd50, 5'd1, 32'd15);
        issue(2'd1, 32'd9, 32'd9, 6'd51, 5'd2, 32'd0);
        issue(2'd3, 32'd11, 32'd13, 6'd52, 5'd3, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        // Output stalled, two more in flight, S0 free: the new op would be taken.
        squash = 1'b1; in_valid = 1'b1; in_func = 2'd0; in_opa = 32'd2; in_opb = 32'd2;
        in_prf_entry = 6'd53; in_rob_entry = 5'd4;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || mult_valid !== 1'b1)
            $display("FAIL squash_pre: got ready=%b valid=%b, required ready=1 valid=1", in_ready, mult_valid);
        else n_pass++;
        @(posedge clock); #1;
        squash = 1'b0; in_valid = 1'b0; mult_ready = 1'b1;
        sb.delete();
        @(negedge clock);
        n_checks++;
        if (mult_valid !== 1'b0) $display("FAIL squash_valid: got %b, required 0", mult_valid);
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (mult_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL squash_ghost: got a result after squash, required none");
        else n_pass++;
        @(posedge clock); #1;
        issue(2'd0, 32'hFFFF_FFFD, 32'd4, 6'd54, 5'd5, 32'hFFFF_FFF4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++;
            if (mult_valid !== (k == 3))
                $display("FAIL squash_after_cycle%0d: got %b, required %b", k, mult_valid, (k == 3));
            else n_pass++;
        end
        @(posedge clock); #1;
        wait_drain("squash");
    endtask

    task automatic test_reset_mid();
        mult_ready = 1'b0;
        issue(2'd0, 32'd100, 32'd200, 6'd60, 5'd7, 32'd20000);
        issue(2'd0, 32'd5, 32'd5, 6'd61, 5'd8, 32'd25);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        n_checks++;
        if (mult_valid !== 1'b1) $display("FAIL rstmid_pre: got valid=%b, required 1", mult_valid);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({mult_valid, mult_value, mult_prf_entry, mult_rob_entry} !== '0)
            $display("FAIL rstmid_async: got valid=%b value=%h prf=%0d rob=%0d, required all 0",
                     mult_valid, mult_value, mult_prf_entry, mult_rob_entry);
        else n_pass++;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0; mult_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || mult_valid !== 1'b0)
            $display("FAIL rstmid_idle: got ready=%b valid=%b, required ready=1 valid=0", in_ready, mult_valid);
        else n_pass++;
        @(posedge clock); #1;
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd62, 5'd9, 32'h4000_0000);
        wait_drain("rstmid");
    endtask

    task automatic test_random();
        logic [1:0]  f;
        logic [31:0] a, b;
        logic        done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    f = 2'($urandom_range(0, 3));
                    a = $urandom; b = $urandom;
                    if (i % 6 == 0) a = 32'h8000_0000;
                    if (i % 5 == 0) b = 32'hFFFF_FFFF;
                    issue(f, a, b, 6'(i), 5'(i), model(f, a, b));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clock); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock); #1;
                    mult_ready = ($urandom_range(0, 2) != 0);
                end
                mult_ready = 1'b1;
            end
        join
        wait_drain("random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_squash();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
